// File: rtl/div_unit.sv
// Iterative RV32M divider: DIV/DIVU/REM/REMU by restoring division, one quotient bit per cycle.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out
);

    localparam int unsigned      CNT_W     = $clog2(XLEN);
    localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONES  = {XLEN{1'b1}};
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   dq_q, dq_d;
    logic [XLEN-1:0]   abs_b_q, abs_b_d;
    logic              op_rem_q, op_rem_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_q, out_d;

    logic              accept;
    logic              is_signed;
    logic              div_zero;
    logic              sgn_ovf;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN:0]     trial;
    logic              q_bit;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   quo_next;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    // Request decode: accept masks flush; magnitudes only for signed ops
    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid & in_ready & ~flush;
    assign is_signed = ~op[0];
    assign div_zero  = (B == '0);
    assign sgn_ovf   = is_signed & (A == MIN_NEG) & (B == ALL_ONES);
    assign abs_a     = (is_signed & A[XLEN-1]) ? -A : A;
    assign abs_b     = (is_signed & B[XLEN-1]) ? -B : B;

    // One restoring step; the final step's values feed the sign fixup directly
    assign trial    = {rem_q, dq_q[XLEN-1]} - {1'b0, abs_b_q};
    assign q_bit    = ~trial[XLEN];
    assign rem_next = q_bit ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], dq_q[XLEN-1]};
    assign quo_next = {dq_q[XLEN-2:0], q_bit};
    assign quo_fix  = neg_quo_q ? -quo_next : quo_next;
    assign rem_fix  = neg_rem_q ? -rem_next : rem_next;

    assign out_valid = out_valid_q;
    assign out       = out_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush wins over every other transition
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = (div_zero || sgn_ovf) ? DONE : CALC;
                CALC:    if (cnt_q == LAST_ITER) state_d = DONE;
                DONE:    if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Registered outputs: result loaded on DONE entry, then held until consumed
    always_comb begin
        out_valid_d = (state_d == DONE);
        out_d       = out_q;
        if (!flush) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (div_zero) begin
                            out_d = op[1] ? A : ALL_ONES;
                        end else if (sgn_ovf) begin
                            out_d = op[1] ? '0 : MIN_NEG;
                        end
                    end
                end
                CALC: begin
                    if (cnt_q == LAST_ITER) out_d = op_rem_q ? rem_fix : quo_fix;
                end
                default: ;
            endcase
        end
    end

    // Datapath: operand capture on accept, one iteration per CALC cycle
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dq_d      = dq_q;
        abs_b_d   = abs_b_q;
        op_rem_d  = op_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (accept) begin
            cnt_d     = '0;
            rem_d     = '0;
            dq_d      = abs_a;
            abs_b_d   = abs_b;
            op_rem_d  = op[1];
            neg_quo_d = is_signed & (A[XLEN-1] ^ B[XLEN-1]);
            neg_rem_d = is_signed & A[XLEN-1];
        end else if ((state_q == CALC) && !flush) begin
            cnt_d = cnt_q + CNT_W'(1);
            rem_d = rem_next;
            dq_d  = quo_next;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            dq_q        <= '0;
            abs_b_q     <= '0;
            op_rem_q    <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dq_q        <= dq_d;
            abs_b_q     <= abs_b_d;
            op_rem_q    <= op_rem_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table, random ops against a reference model, corner sequences.
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    div_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op_i),
        .A         (a_i),
        .B         (b_i),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Reference: RISC-V M-extension semantics, using the simulator's own arithmetic
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00:   return 32'($signed(a) / $signed(b));
            2'b01:   return a / b;
            2'b10:   return 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    // Wait (bounded) for out_valid after the accept edge; returns edges counted from the accept edge
    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic pop_check(input string name);
        logic [31:0] want;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: got %h with empty scoreboard, expected no result", name, out);
        end else begin
            want = exp_q.pop_front();
            check32(name, out, want);
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        int    n;
        string tag;
        tag = $sformatf("op%0d %h/%h", o, a, b);
        @(negedge clk);
        op_i = o; a_i = a; b_i = b; in_valid = 1'b1; out_ready = 1'b1;
        chk_int({tag, " in_ready"}, int'(in_ready), 1);
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        in_valid = 1'b0; op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
        wait_valid(n);
        chk_int({tag, " latency"}, n, lat);
        pop_check({tag, " result"});
        @(posedge clk);
        #1;
        chk_int({tag, " release"}, int'({out_valid, in_ready}), 1);
    endtask

    initial begin
        int n;
        int saw;

        rst_n = 1'b0; in_valid = 1'b0; op_i = 2'd0; a_i = '0; b_i = '0;
        flush = 1'b0; out_ready = 1'b1;

        vecs.push_back('{2'b00, 32'd100,        32'd7,          32'd14,         33});
        vecs.push_back('{2'b10, 32'd100,        32'd7,          32'd2,          33});
        vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
        vecs.push_back('{2'b01, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  33});
        vecs.push_back('{2'b11, 32'hFFFF_FFF9,  32'd2,          32'd1,          33});
        vecs.push_back('{2'b00, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{2'b11, 32'h0000_1234,  32'd0,          32'h0000_1234,  1});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1});
        vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
        vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
        vecs.push_back('{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33});
        vecs.push_back('{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33});
        vecs.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          33});
        vecs.push_back('{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         33});
        vecs.push_back('{2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  33});
        vecs.push_back('{2'b01, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  33});
        vecs.push_back('{2'b11, 32'hDEAD_BEEF,  32'h10,         32'h0000_000F,  33});
        vecs.push_back('{2'b00, 32'd0,          32'd5,          32'd0,          33});

        // Reset state, including in_ready during reset
        #12;
        chk_int("reset flags", int'({out_valid, in_ready}), 1);
        check32("reset out", out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Random operations checked against the reference model
        for (int i = 0; i < 12; i++) begin
            logic [1:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            o = 2'($urandom);
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            do_op(o, a, b, model(o, a, b), is_special(o, a, b) ? 1 : 33);
        end

        // Backpressure: result held while inputs churn
        @(negedge clk);
        op_i = 2'b00; a_i = 32'd100; b_i = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        exp_q.push_back(32'd14);
        #1;
        in_valid = 1'b0;
        wait_valid(n);
        chk_int("bp latency", n, 33);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            a_i = $urandom; b_i = $urandom; op_i = 2'($urandom); in_valid = 1'b1;
            @(posedge clk);
            #1;
            check32("bp hold out", out, 32'd14);
            chk_int("bp hold flags", int'({out_valid, in_ready}), 2);
        end
        @(negedge clk);
        in_valid = 1'b0;
        pop_check("bp consume");
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_int("bp release", int'({out_valid, in_ready}), 1);

        // Flush in CALC cycle 15 with a request presented, then flush in IDLE with a request
        @(negedge clk);
        op_i = 2'b00; a_i = 32'd100; b_i = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(32'd14);
        #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op_i = 2'b00; a_i = 32'h1234; b_i = 32'd0;
        @(posedge clk);
        exp_q.delete();
        #1;
        chk_int("flush to idle", int'({out_valid, in_ready}), 1);
        @(posedge clk);
        #1;
        chk_int("flush masks accept", int'({out_valid, in_ready}), 1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        saw = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) saw = 1;
        end
        chk_int("flush no result", saw, 0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

        // Async reset mid-CALC
        @(negedge clk);
        op_i = 2'b00; a_i = 32'd100; b_i = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(32'd14);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_int("rst calc flags", int'({out_valid, in_ready}), 1);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) saw = 1;
        end
        chk_int("rst calc no result", saw, 0);

        // Async reset mid-DONE
        @(negedge clk);
        op_i = 2'b00; a_i = 32'd5; b_i = 32'd0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk_int("done before rst", int'({out_valid, in_ready}), 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_int("rst done flags", int'({out_valid, in_ready}), 1);
        check32("rst done out", out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        saw = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid) saw = 1;
        end
        chk_int("rst done no result", saw, 0);

        do_op(2'b10, 32'd100, 32'd7, 32'd2, 33);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
